// File: rtl/kb_pkg.sv
// Shared constants and FSM state encoding for the PS/2 scan-code filter.
package kb_pkg;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic {
    IDLE = 1'b0,
    BRK  = 1'b1
  } kb_state_e;

endpackage

// File: rtl/kb_fifo.sv
// First-word-fall-through FIFO; occupancy tracked by a separate count so full/empty
// never depend on pointer equality. Storage is reset so the head reads zero after reset.
module kb_fifo #(
  parameter int W_SIZE = 2,
  parameter int B      = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full
);

  localparam int DEPTH = 2 ** W_SIZE;

  logic [B-1:0]      mem_q [DEPTH];
  logic [W_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [W_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [W_SIZE:0]   count_q, count_d;
  logic              empty_q, full_q;
  logic              wr_en, rd_en;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign wr_en = wr && (!full_q || rd);
  assign rd_en = rd && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_ptr_q] <= w_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == (W_SIZE+1)'(DEPTH));
    end
  end

  assign r_data = mem_q[rd_ptr_q];
  assign empty  = empty_q;
  assign full   = full_q;

endmodule

// File: rtl/kb_scan_filter.sv
// Filters raw PS/2 set-2 bytes into a queue of make codes: drops E0 prefixes,
// swallows F0 break sequences and optionally suppresses typematic repeats.
module kb_scan_filter
  import kb_pkg::*;
#(
  parameter int W_SIZE   = 2,
  parameter int RPT_SUPP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_out,
  input  logic       rd_key_code,
  output logic [7:0] key_code,
  output logic       kb_buf_empty,
  output logic       kb_buf_full,
  output logic       kb_overflow
);

  kb_state_e  state_q, state_d;
  logic [7:0] last_code_q, last_code_d;
  logic       overflow_q, overflow_d;
  logic       push;
  logic       fifo_full;

  always_comb begin
    state_d     = state_q;
    last_code_d = last_code_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    if (scan_done_tick) begin
      case (state_q)
        IDLE: begin
          if (scan_out == BRK_CODE) begin
            state_d = BRK;
          end else if (scan_out != EXT_CODE) begin
            if (!(RPT_SUPP != 0 && scan_out == last_code_q)) begin
              push = 1'b1;
              // A dropped push leaves last_code alone so the key can be retried.
              if (fifo_full && !rd_key_code) overflow_d = 1'b1;
              else                           last_code_d = scan_out;
            end
          end
        end
        BRK: begin
          if (scan_out != EXT_CODE && scan_out != BRK_CODE) begin
            state_d = IDLE;
            if (scan_out == last_code_q) last_code_d = 8'h00;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_code_q <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_code_q <= last_code_d;
      overflow_q  <= overflow_d;
    end
  end

  kb_fifo #(
    .W_SIZE (W_SIZE),
    .B      (8)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (push),
    .rd     (rd_key_code),
    .w_data (scan_out),
    .r_data (key_code),
    .empty  (kb_buf_empty),
    .full   (fifo_full)
  );

  assign kb_buf_full = fifo_full;
  assign kb_overflow = overflow_q;

endmodule
